regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 59 +++++
 tb/tb_regfile_mp.sv | 130 +++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with a per-register busy scoreboard; r0 hardwired to zero.
// Ports: clk, reset (async active-low), wr_en/wr_index/wr_data (write), pend_set/pend_index (mark busy),
//        flush (clear all busy), rd_en/rd_index -> rd_data/rd_busy (NRD combinational read ports), busy_any.
// Macro REGFILE_BYPASS_EN: forward same-cycle write data (and busy=0) to matching read ports.
module regfile_mp #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 32,
  parameter int NRD   = 2,
  localparam int IW   = $clog2(SIZE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [IW-1:0]        wr_index,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 pend_set,
  input  logic [IW-1:0]        pend_index,
  input  logic                 flush,
  input  logic [NRD-1:0]       rd_en,
  input  logic [NRD*IW-1:0]    rd_index,
  output logic [NRD*WIDTH-1:0] rd_data,
  output logic [NRD-1:0]       rd_busy,
  output logic                 busy_any
);
  logic [WIDTH-1:0] mem [SIZE];
  logic [SIZE-1:0]  busy, busy_nxt;
  logic             wr_ok, pend_ok;
  assign wr_ok   = wr_en && wr_index != '0;
  assign pend_ok = pend_set && pend_index != '0;
  // Set is applied last so it beats both the write-clear and the flush.
  always_comb begin
    busy_nxt = flush ? '0 : busy;
    if (wr_ok) busy_nxt[wr_index] = 1'b0;
    if (pend_ok) busy_nxt[pend_index] = 1'b1;
  end
  // mem[0] is never written, so it stays zero from reset onward.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < SIZE; i++) mem[i] <= '0;
      busy <= '0;
    end else begin
      if (wr_ok) mem[wr_index] <= wr_data;
      busy <= busy_nxt;
    end
  assign busy_any = |busy;
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [IW-1:0] idx;
    logic          byp;
    assign idx = rd_index[p*IW +: IW];
`ifdef REGFILE_BYPASS_EN
    // Gated by reset so forwarded data cannot leak out while the file is held cleared.
    assign byp = reset && wr_ok && idx == wr_index;
`else
    assign byp = 1'b0;
`endif
    assign rd_data[p*WIDTH +: WIDTH] = !rd_en[p] ? '0 : byp ? wr_data : mem[idx];
    assign rd_busy[p] = rd_en[p] && !byp && busy[idx];
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed self-checking bench for regfile_mp (default parameters).
module tb_regfile_mp;
  logic        clk = 0;
  logic        reset = 0;
  logic        wr_en = 0, pend_set = 0, flush = 0;
  logic [4:0]  wr_index = 0, pend_index = 0;
  logic [31:0] wr_data = 0;
  logic [1:0]  rd_en = 0;
  logic [9:0]  rd_index = 0;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        busy_any;
  int          errors = 0, checks = 0;
  regfile_mp dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_index(wr_index), .wr_data(wr_data),
    .pend_set(pend_set), .pend_index(pend_index), .flush(flush),
    .rd_en(rd_en), .rd_index(rd_index), .rd_data(rd_data), .rd_busy(rd_busy), .busy_any(busy_any)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic rd(input int p, input logic [4:0] idx);
    rd_en[p] = 1'b1;
    rd_index[p*5 +: 5] = idx;
  endtask
  task automatic wr(input logic [4:0] idx, input logic [31:0] d);
    wr_en = 1'b1;
    wr_index = idx;
    wr_data = d;
  endtask
  task automatic idle();
    wr_en = 0;
    pend_set = 0;
    flush = 0;
  endtask
  initial begin
    tick();
    check("reset_busy_any", {31'b0, busy_any}, 0);
    reset = 1;
    wr(3, 32'h333); tick();
    wr(5, 32'h555); pend_set = 1; pend_index = 4; tick();
    idle(); rd(0, 5); rd(1, 4); #1;
    check("preload_5", rd_data[31:0], 32'h555);
    check("preload_busy4", {31'b0, rd_busy[1]}, 1);
    wr(3, 32'hBAD);
    #2 reset = 0;
    #1;
    check("async_rst_d0", rd_data[31:0], 0);
    check("async_rst_busy", {30'b0, rd_busy}, 0);
    check("async_rst_any", {31'b0, busy_any}, 0);
    rd(1, 3); pend_set = 1; pend_index = 9; flush = 1; tick();
    check("rst_hold_d3", rd_data[63:32], 0);
    check("rst_hold_any", {31'b0, busy_any}, 0);
    idle();
    #3 reset = 1;
    tick();
    check("post_rst_d5", rd_data[31:0], 0);
    check("post_rst_d3_lost", rd_data[63:32], 0);
    check("post_rst_any", {31'b0, busy_any}, 0);
    wr(5, 32'hDEADBEEF); tick();
    idle(); rd(0, 5); rd(1, 5); #1;
    check("rd5_p0", rd_data[31:0], 32'hDEADBEEF);
    check("rd5_p1", rd_data[63:32], 32'hDEADBEEF);
    rd_en[1] = 0; #1;
    check("rd_dis_data", rd_data[63:32], 0);
    wr(0, 32'h1234); tick();
    idle(); rd(0, 0); rd(1, 0); #1;
    check("r0_p0", rd_data[31:0], 0);
    check("r0_p1", rd_data[63:32], 0);
    pend_set = 1; pend_index = 0; tick();
    idle(); #1;
    check("r0_pend_busy", {31'b0, rd_busy[0]}, 0);
    check("r0_pend_any", {31'b0, busy_any}, 0);
    pend_set = 1; pend_index = 7; tick();
    idle(); rd(0, 7); #1;
    check("pend7_busy", {31'b0, rd_busy[0]}, 1);
    check("pend7_any", {31'b0, busy_any}, 1);
    rd_en[0] = 0; #1;
    check("rd_dis_busy", {31'b0, rd_busy[0]}, 0);
    wr(7, 32'h55); tick();
    idle(); rd(0, 7); #1;
    check("wr7_busy", {31'b0, rd_busy[0]}, 0);
    check("wr7_data", rd_data[31:0], 32'h55);
    check("wr7_any", {31'b0, busy_any}, 0);
    wr(9, 32'h99); pend_set = 1; pend_index = 9; tick();
    idle(); rd(1, 9); #1;
    check("setwin9_busy", {31'b0, rd_busy[1]}, 1);
    check("setwin9_data", rd_data[63:32], 32'h99);
    wr(9, 32'h99); tick();
    idle(); pend_set = 1; pend_index = 3; tick();
    pend_index = 4; tick();
    idle(); rd(0, 3); rd(1, 4); #1;
    check("busy3", {31'b0, rd_busy[0]}, 1);
    check("busy4", {31'b0, rd_busy[1]}, 1);
    flush = 1; pend_set = 1; pend_index = 6; tick();
    idle(); #1;
    check("flush3", {31'b0, rd_busy[0]}, 0);
    check("flush4", {31'b0, rd_busy[1]}, 0);
    rd(0, 6); rd(1, 9); #1;
    check("flush_keep6", {31'b0, rd_busy[0]}, 1);
    check("flush_clr9", {31'b0, rd_busy[1]}, 0);
    wr(2, 32'h11); tick();
    idle();
    wr(2, 32'h22); rd(0, 2); rd(1, 6); #1;
`ifdef REGFILE_BYPASS_EN
    check("same_cyc_rd2", rd_data[31:0], 32'h22);
`else
    check("same_cyc_rd2", rd_data[31:0], 32'h11);
`endif
    check("same_cyc_other_busy", {31'b0, rd_busy[1]}, 1);
    tick();
    idle(); #1;
    check("next_cyc_rd2", rd_data[31:0], 32'h22);
    wr(31, 32'hFFFF0000); tick();
    idle(); rd(0, 31); rd(1, 15); #1;
    check("rd31", rd_data[31:0], 32'hFFFF0000);
    check("rd15_noalias", rd_data[63:32], 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
